// File: rtl/paddle_position_ctrl.sv
// Paddle controller: two raw buttons are synchronised, debounced and turned into
// single saturating steps of a 4-bit paddle position. Optional auto-repeat: PADDLE_AUTOREPEAT_EN.
module paddle_position_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int POS_MIN         = 1,
    parameter int POS_MAX         = 8,
    parameter int POS_HOME        = 4,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       enable,
    input  logic       center,
    output logic [3:0] pos,
    output logic       moved
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      P_MIN    = 4'(POS_MIN);
    localparam logic [3:0]      P_MAX    = 4'(POS_MAX);
    localparam logic [3:0]      P_HOME   = 4'(POS_HOME);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]          w_btn;
    logic [1:0]          r_s1;
    logic [1:0]          r_s2;
    logic [1:0]          r_stable;
    logic [1:0]          r_stable_d;
    logic [1:0][CW-1:0]  r_cnt;
    logic [1:0]          w_press;
    logic [1:0]          w_step;
    logic [3:0]          r_pos;
    logic                r_moved;

    assign w_btn   = {btn_dn, btn_up};
    assign w_press = r_stable & ~r_stable_d;

    // Two-flop synchronisers and per-button debounce counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1       <= 2'b00;
            r_s2       <= 2'b00;
            r_stable   <= 2'b00;
            r_stable_d <= 2'b00;
            r_cnt      <= '0;
        end else begin
            r_s1       <= w_btn;
            r_s2       <= r_s1;
            r_stable_d <= r_stable;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef PADDLE_AUTOREPEAT_EN
    localparam int            RMAX      = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int            RW        = $clog2(RMAX + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_CYCLES);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_first;
    logic          w_hold_one;
    logic          w_rep_due;

    // Repeat qualifies only while exactly one button is held in a running game;
    // a counter of 0 means no press has armed it yet.
    always_comb begin
        w_hold_one = enable & (r_stable[0] ^ r_stable[1]) & ~center;
        w_rep_due  = 1'b0;
        if (w_hold_one && (r_rep_cnt != '0)) begin
            w_rep_due = (r_rep_cnt == (r_rep_first ? REP_FIRST : REP_NEXT));
        end else begin
            w_rep_due = 1'b0;
        end
        w_step = w_press | (r_stable & {2{w_rep_due}});
    end

    // Auto-repeat interval counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (!w_hold_one) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (|w_press) begin
            r_rep_cnt   <= RW'(1);
            r_rep_first <= 1'b1;
        end else if (w_rep_due) begin
            r_rep_cnt   <= RW'(1);
            r_rep_first <= 1'b0;
        end else if (r_rep_cnt != '0) begin
            r_rep_cnt   <= r_rep_cnt + RW'(1);
        end else begin
            r_rep_cnt   <= r_rep_cnt;
        end
    end
`else
    assign w_step = w_press;
`endif

    // Position update with center > enable > conflict > up > down priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos   <= P_HOME;
            r_moved <= 1'b0;
        end else if (center) begin
            r_pos   <= P_HOME;
            r_moved <= 1'b0;
        end else if (!enable) begin
            r_moved <= 1'b0;
        end else if (w_step[0] && w_step[1]) begin
            r_moved <= 1'b0;
        end else if (w_step[0]) begin
            if (r_pos < P_MAX) begin
                r_pos   <= r_pos + 4'd1;
                r_moved <= 1'b1;
            end else begin
                r_moved <= 1'b0;
            end
        end else if (w_step[1]) begin
            if (r_pos > P_MIN) begin
                r_pos   <= r_pos - 4'd1;
                r_moved <= 1'b1;
            end else begin
                r_moved <= 1'b0;
            end
        end else begin
            r_moved <= 1'b0;
        end
    end

    assign pos   = r_pos;
    assign moved = r_moved;

endmodule
